// File: rtl/frame_ram_arbiter.sv
// Two-port Wishbone arbiter for a shared byte-wide frame RAM: CPU port A and LED-matrix pixel reader port B.
// Round-robin grant from IDLE, classic and incrementing bursts, forced release after MAX_BURST beats when contended.
module frame_ram_arbiter #(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       DATA_WIDTH    = 8,
  parameter int                       DATA_BYTES    = 1,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = 16'h1000,
  parameter int                       RAM_DEPTH     = 512,
  parameter int                       MAX_BURST     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] a_adr_i,
  input  logic [DATA_WIDTH-1:0]    a_dat_i,
  output logic [DATA_WIDTH-1:0]    a_dat_o,
  input  logic                     a_we_i,
  input  logic [DATA_BYTES-1:0]    a_sel_i,
  input  logic                     a_stb_i,
  input  logic                     a_cyc_i,
  output logic                     a_ack_o,
  input  logic [2:0]               a_cti_i,
  input  logic [ADDRESS_WIDTH-1:0] b_adr_i,
  input  logic [DATA_WIDTH-1:0]    b_dat_i,
  output logic [DATA_WIDTH-1:0]    b_dat_o,
  input  logic                     b_we_i,
  input  logic [DATA_BYTES-1:0]    b_sel_i,
  input  logic                     b_stb_i,
  input  logic                     b_cyc_i,
  output logic                     b_ack_o,
  input  logic [2:0]               b_cti_i
);

  localparam int IDX_W = $clog2(RAM_DEPTH);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int AW1   = ADDRESS_WIDTH + 1;

  // Window bounds carry one extra bit so BASE_ADDRESS+RAM_DEPTH cannot wrap.
  localparam logic [AW1-1:0]   WIN_LO      = {1'b0, BASE_ADDRESS};
  localparam logic [AW1-1:0]   WIN_HI      = WIN_LO + AW1'(RAM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_BURST);
  localparam logic [2:0]       CTI_CLASSIC = 3'b000;
  localparam logic [2:0]       CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  function automatic logic in_window(input logic [ADDRESS_WIDTH-1:0] adr);
    return ({1'b0, adr} >= WIN_LO) && ({1'b0, adr} < WIN_HI);
  endfunction

  function automatic logic [IDX_W-1:0] ram_index(input logic [ADDRESS_WIDTH-1:0] adr);
    return IDX_W'(adr - BASE_ADDRESS);
  endfunction

  state_t                state, next_state;
  logic                  last_grant_b;
  logic [CNT_W-1:0]      beat_cnt, cnt_next;
  logic                  a_req, b_req;
  logic                  acc_a, acc_b, access, sel_b;
  logic [IDX_W-1:0]      ram_idx;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdat;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  assign a_req = a_cyc_i & a_stb_i & in_window(a_adr_i);
  assign b_req = b_cyc_i & b_stb_i & in_window(b_adr_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      last_grant_b <= 1'b1;
      beat_cnt     <= '0;
    end else begin
      state <= next_state;
      if (state != IDLE && next_state == IDLE) last_grant_b <= (state == GRANT_B);
      // Held at zero while idle, so every grant starts counting from zero.
      beat_cnt <= (state == IDLE) ? '0 : cnt_next;
    end
  end

  always_comb begin
    cnt_next = beat_cnt;
    if (access && beat_cnt != CNT_MAX) cnt_next = beat_cnt + CNT_W'(1);
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (a_req && b_req) next_state = last_grant_b ? GRANT_A : GRANT_B;
        else if (a_req)     next_state = GRANT_A;
        else if (b_req)     next_state = GRANT_B;
      end
      GRANT_A: begin
        if (!a_cyc_i || (acc_a && a_cti_i == CTI_END) || (cnt_next == CNT_MAX && b_req))
          next_state = IDLE;
      end
      GRANT_B: begin
        if (!b_cyc_i || (acc_b && b_cti_i == CTI_END) || (cnt_next == CNT_MAX && a_req))
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A classic master still holds stb during its ack cycle; that cycle must not start a second access.
  always_comb begin
    acc_a = 1'b0;
    acc_b = 1'b0;
    case (state)
      GRANT_A: acc_a = a_req && !(a_ack_o && a_cti_i == CTI_CLASSIC);
      GRANT_B: acc_b = b_req && !(b_ack_o && b_cti_i == CTI_CLASSIC);
      default: ;
    endcase
  end

  assign access   = acc_a | acc_b;
  assign sel_b    = (state == GRANT_B);
  assign ram_idx  = sel_b ? ram_index(b_adr_i) : ram_index(a_adr_i);
  assign ram_we   = sel_b ? (b_we_i & b_sel_i[0]) : (a_we_i & a_sel_i[0]);
  assign ram_wdat = sel_b ? b_dat_i : a_dat_i;

  // NOTE: the array and its read register have no reset, so frame contents survive rst_i and map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (access) begin
      if (ram_we) begin
        mem[ram_idx] <= ram_wdat;
        ram_q        <= ram_wdat;
      end else begin
        ram_q <= mem[ram_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_ack_o <= 1'b0;
      b_ack_o <= 1'b0;
    end else begin
      a_ack_o <= acc_a;
      b_ack_o <= acc_b;
    end
  end

  // Read data is only visible to the port being acked; the other port sees zero.
  assign a_dat_o = a_ack_o ? ram_q : '0;
  assign b_dat_o = b_ack_o ? ram_q : '0;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed self-checking bench for frame_ram_arbiter with default parameters.
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.
module tb_frame_ram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] a_adr_i, b_adr_i;
  logic [7:0]  a_dat_i, b_dat_i;
  logic [7:0]  a_dat_o, b_dat_o;
  logic        a_we_i, b_we_i;
  logic [0:0]  a_sel_i, b_sel_i;
  logic        a_stb_i, b_stb_i;
  logic        a_cyc_i, b_cyc_i;
  logic        a_ack_o, b_ack_o;
  logic [2:0]  a_cti_i, b_cti_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  frame_ram_arbiter #(
    .ADDRESS_WIDTH(16),
    .DATA_WIDTH   (8),
    .DATA_BYTES   (1),
    .BASE_ADDRESS (16'h1000),
    .RAM_DEPTH    (512),
    .MAX_BURST    (8)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .a_adr_i(a_adr_i),
    .a_dat_i(a_dat_i),
    .a_dat_o(a_dat_o),
    .a_we_i (a_we_i),
    .a_sel_i(a_sel_i),
    .a_stb_i(a_stb_i),
    .a_cyc_i(a_cyc_i),
    .a_ack_o(a_ack_o),
    .a_cti_i(a_cti_i),
    .b_adr_i(b_adr_i),
    .b_dat_i(b_dat_i),
    .b_dat_o(b_dat_o),
    .b_we_i (b_we_i),
    .b_sel_i(b_sel_i),
    .b_stb_i(b_stb_i),
    .b_cyc_i(b_cyc_i),
    .b_ack_o(b_ack_o),
    .b_cti_i(b_cti_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_idle();
    a_adr_i = '0; a_dat_i = '0; a_we_i = 1'b0; a_sel_i = 1'b1; a_stb_i = 1'b0; a_cyc_i = 1'b0; a_cti_i = 3'b000;
    b_adr_i = '0; b_dat_i = '0; b_we_i = 1'b0; b_sel_i = 1'b1; b_stb_i = 1'b0; b_cyc_i = 1'b0; b_cti_i = 3'b000;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    bus_idle();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // One classic A transfer from IDLE: lat = ticks until ack (-1 if none), extra = ack seen on the tick after release.
  task automatic a_classic(input logic [15:0] adr, input logic we, input logic [7:0] wd, input logic sel,
                           output logic [7:0] rd, output int lat, output logic extra);
    rd = '0;
    lat = -1;
    a_adr_i = adr; a_we_i = we; a_dat_i = wd; a_sel_i = sel; a_cti_i = 3'b000;
    a_cyc_i = 1'b1; a_stb_i = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (a_ack_o) begin
        lat = i;
        rd  = a_dat_o;
        break;
      end
    end
    a_cyc_i = 1'b0; a_stb_i = 1'b0; a_we_i = 1'b0;
    tick();
    extra = a_ack_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    bus_idle();
    a_adr_i = 16'h1000; a_cyc_i = 1'b1; a_stb_i = 1'b1;
    tick();
    tick();
    checks++; if (a_ack_o !== 1'b0) begin errors++; $display("FAIL reset_a_ack: got %b expected 0", a_ack_o); end
    checks++; if (b_ack_o !== 1'b0) begin errors++; $display("FAIL reset_b_ack: got %b expected 0", b_ack_o); end
    checks++; if (a_dat_o !== 8'h00) begin errors++; $display("FAIL reset_a_dat: got %h expected 00", a_dat_o); end
    checks++; if (b_dat_o !== 8'h00) begin errors++; $display("FAIL reset_b_dat: got %h expected 00", b_dat_o); end
    bus_idle();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_classic();
    logic [7:0] rd;
    int         lat;
    logic       extra;
    a_classic(16'h1004, 1'b1, 8'h5A, 1'b1, rd, lat, extra);
    checks++; if (lat !== 2) begin errors++; $display("FAIL classic_wr_latency: got %0d expected 2", lat); end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL classic_wr_single_ack: got %b expected 0", extra); end
    a_classic(16'h1004, 1'b0, 8'h00, 1'b1, rd, lat, extra);
    checks++; if (lat !== 2) begin errors++; $display("FAIL classic_rd_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL classic_rd_data: got %h expected 5a", rd); end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL classic_rd_single_ack: got %b expected 0", extra); end
  endtask

  // A classic master holding stb continuously is acked every other cycle.
  task automatic test_classic_spacing();
    logic exp_ack;
    a_adr_i = 16'h1004; a_we_i = 1'b0; a_sel_i = 1'b1; a_cti_i = 3'b000;
    a_cyc_i = 1'b1; a_stb_i = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      exp_ack = (t % 2 == 0);
      checks++;
      if (a_ack_o !== exp_ack) begin
        errors++; $display("FAIL classic_spacing_t%0d: got %b expected %b", t, a_ack_o, exp_ack);
      end
    end
    a_cyc_i = 1'b0; a_stb_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_sel_masked();
    logic [7:0] rd;
    int         lat;
    logic       extra;
    a_classic(16'h1004, 1'b1, 8'h99, 1'b0, rd, lat, extra);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sel0_write_acked: got %0d expected 2", lat); end
    a_classic(16'h1004, 1'b0, 8'h00, 1'b1, rd, lat, extra);
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL sel0_ram_unchanged: got %h expected 5a", rd); end
  endtask

  task automatic test_burst_b();
    logic [7:0] rd;
    int         lat;
    logic       extra;
    logic [7:0] exp_dat [3];
    logic       exp_ack;
    int         beat;
    exp_dat[0] = 8'h11; exp_dat[1] = 8'h22; exp_dat[2] = 8'h33;
    for (int i = 0; i < 3; i++) a_classic(16'h1000 + 16'(i), 1'b1, exp_dat[i], 1'b1, rd, lat, extra);
    beat = 0;
    b_adr_i = 16'h1000; b_we_i = 1'b0; b_sel_i = 1'b1; b_cti_i = 3'b010;
    b_cyc_i = 1'b1; b_stb_i = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      exp_ack = (t >= 2 && t <= 4);
      checks++;
      if (b_ack_o !== exp_ack) begin
        errors++; $display("FAIL burst_b_ack_t%0d: got %b expected %b", t, b_ack_o, exp_ack);
      end
      if (b_ack_o && beat < 3) begin
        checks++;
        if (b_dat_o !== exp_dat[beat]) begin
          errors++; $display("FAIL burst_b_data_%0d: got %h expected %h", beat, b_dat_o, exp_dat[beat]);
        end
        beat++;
        if (beat == 3) begin
          b_cyc_i = 1'b0; b_stb_i = 1'b0; b_cti_i = 3'b000;
        end else begin
          b_adr_i = 16'h1000 + 16'(beat);
          b_cti_i = (beat == 2) ? 3'b111 : 3'b010;
        end
      end
    end
  endtask

  // After reset A wins the first tie; with last grant A the next tie goes to B. RAM survives reset.
  task automatic test_tie();
    do_reset();
    a_adr_i = 16'h1004; a_cyc_i = 1'b1; a_stb_i = 1'b1;
    b_adr_i = 16'h1000; b_cyc_i = 1'b1; b_stb_i = 1'b1;
    tick();
    tick();
    checks++; if (a_ack_o !== 1'b1) begin errors++; $display("FAIL tie1_a_ack: got %b expected 1", a_ack_o); end
    checks++; if (a_dat_o !== 8'h5A) begin errors++; $display("FAIL tie1_a_dat: got %h expected 5a", a_dat_o); end
    checks++; if (b_ack_o !== 1'b0) begin errors++; $display("FAIL tie1_b_ack: got %b expected 0", b_ack_o); end
    checks++; if (b_dat_o !== 8'h00) begin errors++; $display("FAIL tie1_b_dat: got %h expected 00", b_dat_o); end
    bus_idle();
    tick();
    tick();
    tick();
    a_adr_i = 16'h1004; a_cyc_i = 1'b1; a_stb_i = 1'b1;
    b_adr_i = 16'h1000; b_cyc_i = 1'b1; b_stb_i = 1'b1;
    tick();
    tick();
    checks++; if (b_ack_o !== 1'b1) begin errors++; $display("FAIL tie2_b_ack: got %b expected 1", b_ack_o); end
    checks++; if (b_dat_o !== 8'h11) begin errors++; $display("FAIL tie2_b_dat: got %h expected 11", b_dat_o); end
    checks++; if (a_ack_o !== 1'b0) begin errors++; $display("FAIL tie2_a_ack: got %b expected 0", a_ack_o); end
    checks++; if (a_dat_o !== 8'h00) begin errors++; $display("FAIL tie2_a_dat: got %h expected 00", a_dat_o); end
    bus_idle();
    tick();
    tick();
  endtask

  // A writes a 20-beat burst while B waits with a classic read; A must yield after 8 beats.
  task automatic test_max_burst();
    logic [7:0] rd;
    int         lat;
    logic       extra;
    int         a_acks, a_before_b, b_ack_t, a_last_t;
    logic [7:0] b_data;
    do_reset();
    a_acks = 0; a_before_b = -1; b_ack_t = -1; a_last_t = -1; b_data = '0;
    a_adr_i = 16'h1010; a_dat_i = 8'hA5; a_we_i = 1'b1; a_sel_i = 1'b1; a_cti_i = 3'b010;
    a_cyc_i = 1'b1; a_stb_i = 1'b1;
    b_adr_i = 16'h1000; b_we_i = 1'b0; b_cti_i = 3'b000; b_cyc_i = 1'b1; b_stb_i = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (b_ack_o && b_ack_t < 0) begin
        b_ack_t    = t;
        a_before_b = a_acks;
        b_data     = b_dat_o;
        b_cyc_i = 1'b0; b_stb_i = 1'b0;
      end
      if (a_ack_o) begin
        a_acks++;
        a_last_t = t;
        if (a_acks == 20) begin
          a_cyc_i = 1'b0; a_stb_i = 1'b0; a_we_i = 1'b0;
        end else begin
          a_adr_i = 16'h1010 + 16'(a_acks);
          a_dat_i = 8'(a_acks) ^ 8'hA5;
          a_cti_i = (a_acks == 19) ? 3'b111 : 3'b010;
        end
      end
      if (a_acks == 20 && b_ack_t >= 0) break;
    end
    bus_idle();
    tick();
    checks++; if (a_before_b !== 8) begin errors++; $display("FAIL maxburst_a_beats_before_b: got %0d expected 8", a_before_b); end
    checks++; if (b_ack_t !== 11) begin errors++; $display("FAIL maxburst_b_ack_cycle: got %0d expected 11", b_ack_t); end
    checks++; if (b_data !== 8'h11) begin errors++; $display("FAIL maxburst_b_data: got %h expected 11", b_data); end
    checks++; if (a_acks !== 20) begin errors++; $display("FAIL maxburst_a_total_acks: got %0d expected 20", a_acks); end
    checks++; if (a_last_t !== 25) begin errors++; $display("FAIL maxburst_a_last_ack_cycle: got %0d expected 25", a_last_t); end
    a_classic(16'h1010, 1'b0, 8'h00, 1'b1, rd, lat, extra);
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL maxburst_readback_first: got %h expected a5", rd); end
    a_classic(16'h1023, 1'b0, 8'h00, 1'b1, rd, lat, extra);
    checks++; if (rd !== 8'hB6) begin errors++; $display("FAIL maxburst_readback_last: got %h expected b6", rd); end
  endtask

  // 0x0FFF aliases index 0x1FF and 0x1200 aliases index 0; neither may be acked or written.
  task automatic test_out_of_range();
    logic [7:0] rd;
    int         lat;
    logic       extra;
    int         a_cnt, b_cnt;
    a_classic(16'h11FF, 1'b1, 8'h77, 1'b1, rd, lat, extra);
    checks++; if (lat !== 2) begin errors++; $display("FAIL range_top_in_window: got %0d expected 2", lat); end
    a_cnt = 0; b_cnt = 0;
    a_adr_i = 16'h0FFF; a_dat_i = 8'hEE; a_we_i = 1'b1; a_cyc_i = 1'b1; a_stb_i = 1'b1;
    b_adr_i = 16'h1200; b_dat_i = 8'hDD; b_we_i = 1'b1; b_cyc_i = 1'b1; b_stb_i = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (a_ack_o) a_cnt++;
      if (b_ack_o) b_cnt++;
    end
    bus_idle();
    tick();
    checks++; if (a_cnt !== 0) begin errors++; $display("FAIL range_below_acks: got %0d expected 0", a_cnt); end
    checks++; if (b_cnt !== 0) begin errors++; $display("FAIL range_above_acks: got %0d expected 0", b_cnt); end
    a_classic(16'h1000, 1'b0, 8'h00, 1'b1, rd, lat, extra);
    checks++; if (rd !== 8'h11) begin errors++; $display("FAIL range_ram0_unchanged: got %h expected 11", rd); end
    a_classic(16'h11FF, 1'b0, 8'h00, 1'b1, rd, lat, extra);
    checks++; if (rd !== 8'h77) begin errors++; $display("FAIL range_ram1ff_unchanged: got %h expected 77", rd); end
  endtask

  task automatic test_read_after_write();
    int         ack_t2;
    logic [7:0] rd2;
    int         acks;
    acks = 0; ack_t2 = -1; rd2 = '0;
    a_adr_i = 16'h1020; a_dat_i = 8'h3C; a_we_i = 1'b1; a_sel_i = 1'b1; a_cti_i = 3'b010;
    a_cyc_i = 1'b1; a_stb_i = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (a_ack_o) begin
        acks++;
        if (acks == 1) begin
          a_we_i = 1'b0; a_cti_i = 3'b111;
        end else if (acks == 2) begin
          ack_t2 = t;
          rd2    = a_dat_o;
          a_cyc_i = 1'b0; a_stb_i = 1'b0;
        end
      end
    end
    bus_idle();
    checks++; if (ack_t2 !== 3) begin errors++; $display("FAIL raw_second_ack_cycle: got %0d expected 3", ack_t2); end
    checks++; if (rd2 !== 8'h3C) begin errors++; $display("FAIL raw_read_data: got %h expected 3c", rd2); end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] rd;
    int         lat;
    logic       extra;
    b_adr_i = 16'h1010; b_we_i = 1'b0; b_sel_i = 1'b1; b_cti_i = 3'b010;
    b_cyc_i = 1'b1; b_stb_i = 1'b1;
    tick();
    tick();
    checks++; if (b_ack_o !== 1'b1 || b_dat_o !== 8'hA5) begin
      errors++; $display("FAIL midrst_beat0: got ack %b dat %h expected ack 1 dat a5", b_ack_o, b_dat_o);
    end
    b_adr_i = 16'h1011;
    tick();
    checks++; if (b_ack_o !== 1'b1 || b_dat_o !== 8'hA4) begin
      errors++; $display("FAIL midrst_beat1: got ack %b dat %h expected ack 1 dat a4", b_ack_o, b_dat_o);
    end
    b_adr_i = 16'h1012;
    rst_i = 1'b1;
    tick();
    checks++; if (b_ack_o !== 1'b0) begin errors++; $display("FAIL midrst_b_ack: got %b expected 0", b_ack_o); end
    checks++; if (b_dat_o !== 8'h00) begin errors++; $display("FAIL midrst_b_dat: got %h expected 00", b_dat_o); end
    rst_i = 1'b0;
    bus_idle();
    tick();
    a_classic(16'h1011, 1'b0, 8'h00, 1'b1, rd, lat, extra);
    checks++; if (lat !== 2) begin errors++; $display("FAIL midrst_idle_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 8'hA4) begin errors++; $display("FAIL midrst_ram_kept: got %h expected a4", rd); end
  endtask

  initial begin
    test_reset();
    test_classic();
    test_classic_spacing();
    test_sel_masked();
    test_burst_b();
    test_tie();
    test_max_burst();
    test_out_of_range();
    test_read_after_write();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
